// File: rtl/layer_bridge.sv
// layer_bridge: accepts a whole layer vector in one cycle and streams it
// out one activation word per handshake. Two vector buffers are used in
// ping-pong fashion so a new vector can land while the previous one is
// still draining. Vectors offered while both buffers are busy are dropped
// and counted.
module layer_bridge #(
    parameter int dataWidth = 16,
    parameter int neurons   = 16,
    parameter int order     = 0,
    parameter int dropWidth = 8,
    localparam int idxWidth = $clog2(neurons)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [neurons*dataWidth-1:0]  in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [dataWidth-1:0]          out_data,
    output logic [idxWidth-1:0]           out_index,
    output logic                          out_last,
    output logic                          overflow,
    output logic [dropWidth-1:0]          drop_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [idxWidth-1:0]  last_pos = idxWidth'(neurons - 1);
    localparam logic [dropWidth-1:0] drop_max = {dropWidth{1'b1}};

    // Buffer storage carries no reset; occupancy decides what is meaningful.
    logic [neurons*dataWidth-1:0] vec_buf_r [2];

    state_t                 state_r, state_s;
    logic [1:0]             count_r, count_s;
    logic                   wr_ptr_r, wr_ptr_s;
    logic                   rd_ptr_r, rd_ptr_s;
    logic [idxWidth-1:0]    pos_r, pos_s;
    logic                   overflow_r, overflow_s;
    logic [dropWidth-1:0]   drop_count_r, drop_count_s;

    logic                   out_valid_s;
    logic                   xfer_s;
    logic                   last_xfer_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   drop_s;
    logic [idxWidth-1:0]    word_idx_s;

    // A full pair of buffers can still take a vector in the cycle the
    // draining one hands over its final word.
    assign out_valid_s = (count_r != 2'd0);
    assign xfer_s      = out_valid_s & out_ready;
    assign last_xfer_s = xfer_s & (pos_r == last_pos);
    assign in_ready_s  = (count_r < 2'd2) | ((count_r == 2'd2) & last_xfer_s);
    assign accept_s    = in_valid & in_ready_s;
    assign drop_s      = in_valid & ~in_ready_s;
    assign word_idx_s  = (order != 0) ? (last_pos - pos_r) : pos_r;

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_index  = word_idx_s;
    assign out_last   = out_valid_s & (pos_r == last_pos);
    assign out_data   = vec_buf_r[rd_ptr_r][int'(word_idx_s) * dataWidth +: dataWidth];
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

    // Next-state computation for pointers, occupancy, word position, drops and FSM.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        pos_s        = pos_r;
        overflow_s   = drop_s;
        drop_count_s = drop_count_r;

        if (xfer_s) begin
            if (pos_r == last_pos) begin
                pos_s    = {idxWidth{1'b0}};
                rd_ptr_s = ~rd_ptr_r;
            end else begin
                pos_s = pos_r + idxWidth'(1);
            end
        end else begin
            pos_s = pos_r;
        end

        if (accept_s) begin
            wr_ptr_s = ~wr_ptr_r;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end

        case ({accept_s, last_xfer_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase

        if (drop_s && (drop_count_r != drop_max)) begin
            drop_count_s = drop_count_r + dropWidth'(1);
        end else begin
            drop_count_s = drop_count_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (last_xfer_s && !accept_s && (count_r == 2'd1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= 2'd0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            pos_r        <= {idxWidth{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= {dropWidth{1'b0}};
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            pos_r        <= pos_s;
            overflow_r   <= overflow_s;
            drop_count_r <= drop_count_s;
        end
    end

    // Capture an accepted vector into the buffer selected by the write pointer.
    always_ff @(posedge clk) begin
        if (rst_n && accept_s) begin
            vec_buf_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: tb/tb_layer_bridge.sv
// Testbench for layer_bridge (neurons=4, dataWidth=16, dropWidth=2).
// Two instances, one per stream order, share all inputs. A queue-based
// reference model predicts every output each cycle.
module tb_layer_bridge;

    localparam int DW = 16;
    localparam int NN = 4;
    localparam int XW = 2;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [NN*DW-1:0]   in_data = '0;
    logic               out_ready = 1'b0;

    logic               in_ready0, out_valid0, out_last0, overflow0;
    logic [DW-1:0]      out_data0;
    logic [IW-1:0]      out_index0;
    logic [XW-1:0]      drop_count0;
    logic               in_ready1, out_valid1, out_last1, overflow1;
    logic [DW-1:0]      out_data1;
    logic [IW-1:0]      out_index1;
    logic [XW-1:0]      drop_count1;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [NN*DW-1:0] mq[$];
    int  m_pos = 0;
    int  m_drops = 0;
    bit  m_ovf = 1'b0;
    bit  m_known = 1'b0;

    always #5 clk = ~clk;

    layer_bridge #(.dataWidth(DW), .neurons(NN), .order(0), .dropWidth(XW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_index(out_index0), .out_last(out_last0),
        .overflow(overflow0), .drop_count(drop_count0)
    );

    layer_bridge #(.dataWidth(DW), .neurons(NN), .order(1), .dropWidth(XW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_index(out_index1), .out_last(out_last1),
        .overflow(overflow1), .drop_count(drop_count1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Compare both instances against the model for the current cycle.
    task automatic compare_all();
        bit          ev;
        bit          el;
        bit          er;
        int          k0;
        int          k1;
        logic [NN*DW-1:0] vec;
        logic [31:0] w0;
        logic [31:0] w1;
        ev = (mq.size() > 0);
        el = ev && (m_pos == NN - 1);
        er = (mq.size() < 2) || ((mq.size() == 2) && out_ready && el);
        check_val("in_ready0",  32'(in_ready0),  32'(er));
        check_val("in_ready1",  32'(in_ready1),  32'(er));
        check_val("out_valid0", 32'(out_valid0), 32'(ev));
        check_val("out_valid1", 32'(out_valid1), 32'(ev));
        check_val("out_last0",  32'(out_last0),  32'(el));
        check_val("out_last1",  32'(out_last1),  32'(el));
        check_val("overflow0",  32'(overflow0),  32'(m_ovf));
        check_val("overflow1",  32'(overflow1),  32'(m_ovf));
        check_val("drop_cnt0",  32'(drop_count0), 32'(m_drops));
        check_val("drop_cnt1",  32'(drop_count1), 32'(m_drops));
        if (ev) begin
            vec = mq[0];
            k0 = m_pos;
            k1 = NN - 1 - m_pos;
            w0 = 32'(vec[k0*DW +: DW]);
            w1 = 32'(vec[k1*DW +: DW]);
            check_val("out_data0",  32'(out_data0),  w0);
            check_val("out_data1",  32'(out_data1),  w1);
            check_val("out_index0", 32'(out_index0), 32'(k0));
            check_val("out_index1", 32'(out_index1), 32'(k1));
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_edge(input bit rst, input bit v, input logic [NN*DW-1:0] d, input bit r);
        bit last;
        bit rdy;
        if (!rst) begin
            mq.delete();
            m_pos = 0;
            m_drops = 0;
            m_ovf = 1'b0;
            m_known = 1'b1;
        end else begin
            last = (mq.size() > 0) && r && (m_pos == NN - 1);
            rdy  = (mq.size() < 2) || ((mq.size() == 2) && last);
            if ((mq.size() > 0) && r) begin
                if (last) begin
                    void'(mq.pop_front());
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (v && rdy) mq.push_back(d);
            m_ovf = v && !rdy;
            if (v && !rdy && (m_drops < (1 << XW) - 1)) m_drops++;
        end
    endtask

    // One clock cycle: drive inputs, check outputs, then update the model.
    task automatic cyc(input bit rst, input bit v, input logic [NN*DW-1:0] d, input bit r);
        @(posedge clk);
        #1;
        rst_n     = rst;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #3;
        if (m_known) compare_all();
        model_edge(rst, v, d, r);
    endtask

    localparam logic [NN*DW-1:0] VEC_A = 64'h0004_0003_0002_0001;

    initial begin
        logic [NN*DW-1:0] rv;
        // Reset
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        // Basic vector, continuous ready (both orders checked together)
        cyc(1'b1, 1'b1, VEC_A, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
        // Stall after word 1 for three cycles
        cyc(1'b1, 1'b1, VEC_A, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        // Three consecutive vectors while stalled: third is dropped
        cyc(1'b1, 1'b1, 64'h1114_1113_1112_1111, 1'b0);
        cyc(1'b1, 1'b1, 64'h2224_2223_2222_2221, 1'b0);
        cyc(1'b1, 1'b1, 64'h3334_3333_3332_3331, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        // Fill again, then five more drops to saturate the counter
        cyc(1'b1, 1'b1, 64'h4444_4443_4442_4441, 1'b0);
        cyc(1'b1, 1'b1, 64'h5554_5553_5552_5551, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        check_val("drop_sat0", 32'(drop_count0), 32'd3);
        check_val("drop_sat1", 32'(drop_count1), 32'd3);
        // Drain to the last word of the first vector with count==2, then
        // offer a vector exactly on that transfer
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b1, 64'h6664_6663_6662_6661, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        // Reset during word 2
        cyc(1'b1, 1'b1, 64'h7774_7773_7772_7771, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        check_val("rst_valid0", 32'(out_valid0), 32'd0);
        check_val("rst_drops0", 32'(drop_count0), 32'd0);
        cyc(1'b1, 1'b1, VEC_A, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rv = {$urandom, $urandom};
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0), rv,
                ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, '0, 1'b1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/layer_bridge.md
LAYER_BRIDGE -- requirements
Module: layer_bridge

Interface
REQ-001 SHALL have parameter dataWidth, default 16, meaning bits per neuron activation word.
REQ-002 SHALL have parameter neurons, default 16, meaning words per layer vector; legal range 2..64.
REQ-003 SHALL have parameter order, default 0, meaning stream order: 0 sends index 0 first, 1 sends index neurons-1 first.
REQ-004 SHALL have parameter dropWidth, default 8, meaning width of the dropped-vector counter.
REQ-005 SHALL derive localparam idxWidth = $clog2(neurons).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 in_valid  input  1  one-cycle strobe: in_data holds a complete layer vector.
REQ-009 in_data  input  neurons*dataWidth  parallel vector; word k at bits [k*dataWidth +: dataWidth].
REQ-010 in_ready  output  1  high when a vector offered this cycle is accepted.
REQ-011 out_valid  output  1  out_data/out_index/out_last are valid.
REQ-012 out_ready  input  1  downstream accepts the current word.
REQ-013 out_data  output  dataWidth  current serialized word.
REQ-014 out_index  output  idxWidth  neuron index of out_data within its vector.
REQ-015 out_last  output  1  high on the final word of a vector.
REQ-016 overflow  output  1  one-cycle pulse: an offered vector was dropped.
REQ-017 drop_count  output  dropWidth  number of dropped vectors, saturating.

Function
REQ-018 SHALL hold two vector buffers (ping-pong) with write pointer, read pointer, occupancy count 0..2 and word counter pos 0..neurons-1.
REQ-019 SHALL use FSM states IDLE (count=0) and SEND (count>=1); IDLE->SEND on accept; SEND->IDLE when the last word of the only buffered vector transfers and no vector is accepted that cycle.
REQ-020 SHALL drive in_ready = (count<2) or (count==2 and out_valid and out_ready and out_last), combinationally from registered state and out_ready.
REQ-021 SHALL capture in_data into the write buffer on in_valid and in_ready, toggle the write pointer and increment count, all in the same edge.
REQ-022 SHALL drop the vector on in_valid and not in_ready: buffers unchanged, overflow high for exactly that following cycle, drop_count +1, saturating at 2^dropWidth-1.
REQ-023 SHALL assert out_valid iff count>0; first word of a vector captured at edge T is presented in the cycle after T (1-cycle latency).
REQ-024 SHALL present word k = pos (order 0) or neurons-1-pos (order 1) of the read buffer on out_data; out_index = k.
REQ-025 SHALL assert out_last iff out_valid and pos == neurons-1.
REQ-026 SHALL advance pos on out_valid and out_ready; on the last word reset pos to 0, toggle read pointer and decrement count.
REQ-027 SHALL hold out_data, out_index and out_last stable while out_valid and not out_ready.
REQ-028 SHALL, on simultaneous accept and last-word transfer, leave count unchanged and begin the next vector in the immediately following cycle with no bubble.
REQ-029 SHALL stream back-to-back vectors with no idle cycle between out_last and the next word 0 when out_ready stays high.
REQ-030 SHALL ignore in_data contents when in_valid is low.

Reset
REQ-031 SHALL, while rst_n is low at a clock edge, set count=0, pointers=0, pos=0, drop_count=0, overflow=0, state=IDLE; thus out_valid=0, out_last=0, in_ready=1.
REQ-032 SHALL discard any buffered or partially streamed vector when reset is asserted mid-stream; no word of it appears after reset.
REQ-033 Buffer contents SHALL need no reset.

Verification (neurons=4, dataWidth=16, dropWidth=2)
REQ-034 in_valid with words {0x0001,0x0002,0x0003,0x0004}, out_ready=1, order=0 -> next 4 cycles out_data 0001,0002,0003,0004, out_index 0..3, out_last only on 0004, then out_valid=0.
REQ-035 same vector with order=1 -> out_data 0004,0003,0002,0001, out_index 3,2,1,0, out_last on 0001.
REQ-036 out_ready=0 for 3 cycles after word 1 -> out_data=0002 and out_index=1 held stable; stream resumes unchanged.
REQ-037 out_ready=0, three vectors offered on consecutive cycles -> first two accepted, third dropped, overflow pulses once, drop_count=1; then out_ready=1 -> 8 words in order, no bubble between vectors; five further drops -> drop_count saturates at 3.
REQ-038 count=2 and in_valid coincides with the last-word transfer -> vector accepted, in_ready=1, no overflow.
REQ-039 rst_n low for one cycle during word 2 -> out_valid=0 the next cycle, drop_count=0, and a new vector afterwards streams from index 0.
